// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM stage: load/store info codes, FSM states and
// the load misalignment rule.
package mem_access_pkg;

  localparam logic [1:0] SN = 2'b00;
  localparam logic [1:0] SB = 2'b01;
  localparam logic [1:0] SH = 2'b10;
  localparam logic [1:0] SW = 2'b11;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LN  = 3'b111;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_WAIT = 2'd2
  } ma_state_t;

  function automatic logic is_load(input logic [2:0] info);
    return info inside {LB, LBU, LH, LHU, LW};
  endfunction

  // Halfwords only straddle the word boundary at offset 3.
  function automatic logic load_misaligned(input logic [2:0] info, input logic [1:0] r);
    case (info)
      LH, LHU: return r == 2'b11;
      LW:      return r != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_store_align.sv
// Replicates store data onto the byte lanes selected by the address remainder
// and flags stores that would cross a word boundary.
module mem_access_store_align
  import mem_access_pkg::*;
(
  input  logic [31:0] d,
  input  logic [1:0]  r,
  input  logic [1:0]  info_store,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misalign_st
);

  always_comb begin
    wdata       = 32'h0;
    be          = 4'b0000;
    misalign_st = 1'b0;
    case (info_store)
      SB: begin
        wdata = {4{d[7:0]}};
        be    = 4'b0001 << r;
      end
      SH: begin
        wdata       = {2{d[15:0]}} << {r, 3'b000};
        be          = 4'b0011 << r;
        misalign_st = (r == 2'b11);
      end
      SW: begin
        wdata       = d;
        be          = 4'b1111;
        misalign_st = (r != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: issues aligned loads/stores over a req/gnt/rvalid bus,
// stalls EX while busy and hands registered results to the load formatter.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] ex_wdata,
  input  logic [2:0]  info_load,
  input  logic [1:0]  info_store,
  input  logic [4:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] addr_data,
  output logic [1:0]  addr_rem,
  output logic [2:0]  info_load_o,
  output logic [31:0] alu_result_o,
  output logic [4:0]  wb_rd,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [31:0] TIMEOUT_CYC = 32'(TIMEOUT);

  ma_state_t   state, state_nxt;
  logic [31:0] wait_cnt, wait_cnt_nxt;

  logic        ex_ready_nxt, dmem_req_nxt, dmem_we_nxt, wb_valid_nxt;
  logic [31:0] dmem_addr_nxt, dmem_wdata_nxt, addr_data_nxt, alu_result_o_nxt;
  logic [3:0]  dmem_be_nxt;
  logic [1:0]  addr_rem_nxt;
  logic [2:0]  info_load_o_nxt;
  logic [4:0]  wb_rd_nxt;
  logic        misalign_nxt, bus_err_nxt;

  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic        st_mis;
  logic        is_store, is_ld, mem_op, mis;

  mem_access_store_align u_store_align (
    .d           (ex_wdata),
    .r           (alu_result[1:0]),
    .info_store  (info_store),
    .wdata       (st_wdata),
    .be          (st_be),
    .misalign_st (st_mis)
  );

  // A store wins over a simultaneous load, so only store alignment applies then.
  assign is_store = (info_store != SN);
  assign is_ld    = is_load(info_load);
  assign mem_op   = is_store || is_ld;
  assign mis      = is_store ? st_mis : (is_ld && load_misaligned(info_load, alu_result[1:0]));

  always_comb begin
    state_nxt        = state;
    wait_cnt_nxt     = wait_cnt;
    dmem_req_nxt     = dmem_req;
    dmem_we_nxt      = dmem_we;
    dmem_addr_nxt    = dmem_addr;
    dmem_wdata_nxt   = dmem_wdata;
    dmem_be_nxt      = dmem_be;
    wb_valid_nxt     = 1'b0;
    addr_data_nxt    = addr_data;
    addr_rem_nxt     = addr_rem;
    info_load_o_nxt  = info_load_o;
    alu_result_o_nxt = alu_result_o;
    wb_rd_nxt        = wb_rd;
    misalign_nxt     = misalign;
    bus_err_nxt      = bus_err;

    case (state)
      MA_IDLE: begin
        if (ex_valid) begin
          addr_rem_nxt     = alu_result[1:0];
          info_load_o_nxt  = is_store ? LN : info_load;
          alu_result_o_nxt = alu_result;
          wb_rd_nxt        = ex_rd;
          addr_data_nxt    = 32'h0;
          bus_err_nxt      = 1'b0;
          misalign_nxt     = mis;
          if (!mem_op || mis) begin
            wb_valid_nxt = 1'b1;
          end else begin
            dmem_req_nxt   = 1'b1;
            dmem_we_nxt    = is_store;
            dmem_addr_nxt  = {alu_result[31:2], 2'b00};
            dmem_wdata_nxt = is_store ? st_wdata : 32'h0;
            dmem_be_nxt    = is_store ? st_be : 4'b0000;
            state_nxt      = MA_REQ;
          end
        end
      end
      MA_REQ: begin
        if (dmem_gnt) begin
          dmem_req_nxt = 1'b0;
          if (dmem_we) begin
            wb_valid_nxt = 1'b1;
            state_nxt    = MA_IDLE;
          end else begin
            wait_cnt_nxt = 32'h0;
            state_nxt    = MA_WAIT;
          end
        end
      end
      MA_WAIT: begin
        wait_cnt_nxt = wait_cnt + 32'd1;
        if (dmem_rvalid) begin
          addr_data_nxt = dmem_rdata;
          wb_valid_nxt  = 1'b1;
          state_nxt     = MA_IDLE;
        end else if (TIMEOUT != 0 && (wait_cnt + 32'd1) == TIMEOUT_CYC) begin
          bus_err_nxt  = 1'b1;
          wb_valid_nxt = 1'b1;
          state_nxt    = MA_IDLE;
        end
      end
      default: state_nxt = MA_IDLE;
    endcase

    ex_ready_nxt = (state_nxt == MA_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= MA_IDLE;
      wait_cnt     <= 32'h0;
      ex_ready     <= 1'b1;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'h0;
      dmem_wdata   <= 32'h0;
      dmem_be      <= 4'b0000;
      wb_valid     <= 1'b0;
      addr_data    <= 32'h0;
      addr_rem     <= 2'b00;
      info_load_o  <= 3'b000;
      alu_result_o <= 32'h0;
      wb_rd        <= 5'd0;
      misalign     <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_cnt_nxt;
      ex_ready     <= ex_ready_nxt;
      dmem_req     <= dmem_req_nxt;
      dmem_we      <= dmem_we_nxt;
      dmem_addr    <= dmem_addr_nxt;
      dmem_wdata   <= dmem_wdata_nxt;
      dmem_be      <= dmem_be_nxt;
      wb_valid     <= wb_valid_nxt;
      addr_data    <= addr_data_nxt;
      addr_rem     <= addr_rem_nxt;
      info_load_o  <= info_load_o_nxt;
      alu_result_o <= alu_result_o_nxt;
      wb_rd        <= wb_rd_nxt;
      misalign     <= misalign_nxt;
      bus_err      <= bus_err_nxt;
    end
  end

endmodule
